// File: rtl/pbkdf2_hmac_iter_if.sv
// Request/result and SHA-256 wrapper signal bundle for pbkdf2_hmac_iter.
// Every valid/ready pair transfers on a clock edge where both are high; valid and its data hold until then.
interface pbkdf2_hmac_iter_if #(
    parameter int SALT_W = 32
);
    logic [511:0]      pass_i;
    logic [SALT_W-1:0] salt_i;
    logic [31:0]       blk_idx_i;
    logic [31:0]       iter_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [255:0]      dk_o;
    logic              dk_valid_o;
    logic              dk_ready_i;
    logic [1023:0]     hash_in_o;
    logic              hash_in_valid_o;
    logic              hash_in_ready_i;
    logic [255:0]      hash_out_i;
    logic              hash_out_valid_i;
    logic              hash_out_ready_o;

    modport slave (
        input  pass_i, salt_i, blk_idx_i, iter_i, req_valid_i, dk_ready_i,
        input  hash_in_ready_i, hash_out_i, hash_out_valid_i,
        output req_ready_o, dk_o, dk_valid_o, hash_in_o, hash_in_valid_o, hash_out_ready_o
    );

    modport master (
        output pass_i, salt_i, blk_idx_i, iter_i, req_valid_i, dk_ready_i,
        output hash_in_ready_i, hash_out_i, hash_out_valid_i,
        input  req_ready_o, dk_o, dk_valid_o, hash_in_o, hash_in_valid_o, hash_out_ready_o
    );
endinterface

// File: rtl/pbkdf2_hmac_iter.sv
// PBKDF2-HMAC-SHA256 block iterator: drives a 1024-bit SHA-256 wrapper and XOR-accumulates U1..Uc.
// Optional PBKDF2_PROGRESS_EN adds progress_o (completed iteration count).
module pbkdf2_hmac_iter #(
    parameter int SALT_W = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    pbkdf2_hmac_iter_if.slave bus,
`ifdef PBKDF2_PROGRESS_EN
    output logic [31:0] progress_o,
`endif
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IREQ  = 3'd1,
        IWAIT = 3'd2,
        OREQ  = 3'd3,
        OWAIT = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [511:0] IPAD = {64{8'h36}};
    localparam logic [511:0] OPAD = {64{8'h5c}};
    localparam logic [63:0]  L1   = 64'(512 + SALT_W + 32);

    state_t       state;
    logic [511:0] pass_q;
    logic [31:0]  iter_q;
    logic [31:0]  j_q;
    logic [255:0] acc_q;

    assign state_o = state;

    // First inner message: key block, salt, index, then SHA padding for a 64-byte-prefixed message.
    function automatic logic [1023:0] first_inner(input logic [511:0] pass,
                                                  input logic [SALT_W-1:0] salt,
                                                  input logic [31:0] idx);
        logic [1023:0] m;
        m = '0;
        m[1023:512]           = pass ^ IPAD;
        m[511 -: SALT_W]      = salt;
        m[511-SALT_W -: 32]   = idx;
        m[479-SALT_W]         = 1'b1;
        m[63:0]               = L1;
        return m;
    endfunction

    function automatic logic [1023:0] chained(input logic [511:0] key, input logic [255:0] d);
        return {key, d, 1'b1, 191'b0, 64'd768};
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state                <= IDLE;
            pass_q               <= '0;
            iter_q               <= '0;
            j_q                  <= '0;
            acc_q                <= '0;
            bus.req_ready_o      <= 1'b0;
            bus.dk_o             <= '0;
            bus.dk_valid_o       <= 1'b0;
            bus.hash_in_o        <= '0;
            bus.hash_in_valid_o  <= 1'b0;
            bus.hash_out_ready_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_ready_o && bus.req_valid_i) begin
                        pass_q              <= bus.pass_i;
                        iter_q              <= (bus.iter_i == 32'd0) ? 32'd1 : bus.iter_i;
                        j_q                 <= 32'd1;
                        acc_q               <= '0;
                        bus.req_ready_o     <= 1'b0;
                        bus.hash_in_o       <= first_inner(bus.pass_i, bus.salt_i, bus.blk_idx_i);
                        bus.hash_in_valid_o <= 1'b1;
                        state               <= IREQ;
                    end else begin
                        bus.req_ready_o <= 1'b1;
                    end
                end
                IREQ: begin
                    if (bus.hash_in_ready_i) begin
                        bus.hash_in_valid_o  <= 1'b0;
                        bus.hash_out_ready_o <= 1'b1;
                        state                <= IWAIT;
                    end
                end
                IWAIT: begin
                    // The message register doubles as the holder of the inner digest.
                    if (bus.hash_out_valid_i) begin
                        bus.hash_out_ready_o <= 1'b0;
                        bus.hash_in_o        <= chained(pass_q ^ OPAD, bus.hash_out_i);
                        bus.hash_in_valid_o  <= 1'b1;
                        state                <= OREQ;
                    end
                end
                OREQ: begin
                    if (bus.hash_in_ready_i) begin
                        bus.hash_in_valid_o  <= 1'b0;
                        bus.hash_out_ready_o <= 1'b1;
                        state                <= OWAIT;
                    end
                end
                OWAIT: begin
                    if (bus.hash_out_valid_i) begin
                        bus.hash_out_ready_o <= 1'b0;
                        acc_q                <= acc_q ^ bus.hash_out_i;
                        if (j_q == iter_q) begin
                            bus.dk_o       <= acc_q ^ bus.hash_out_i;
                            bus.dk_valid_o <= 1'b1;
                            state          <= DONE;
                        end else begin
                            j_q                 <= j_q + 32'd1;
                            bus.hash_in_o       <= chained(pass_q ^ IPAD, bus.hash_out_i);
                            bus.hash_in_valid_o <= 1'b1;
                            state               <= IREQ;
                        end
                    end
                end
                DONE: begin
                    if (bus.dk_ready_i) begin
                        bus.dk_valid_o  <= 1'b0;
                        bus.req_ready_o <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PBKDF2_PROGRESS_EN
    logic [31:0] prog_q;
    assign progress_o = prog_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prog_q <= '0;
        end else if (state == IDLE && bus.req_ready_o && bus.req_valid_i) begin
            prog_q <= '0;
        end else if (state == OWAIT && bus.hash_out_valid_i) begin
            prog_q <= prog_q + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pbkdf2_hmac_iter.sv
// Bench for pbkdf2_hmac_iter: emulates the SHA-256 wrapper and compares against a byte-level PBKDF2 model.
module tb_pbkdf2_hmac_iter;
    localparam int SALT_W = 32;
    typedef logic [7:0] bq_t[$];

    localparam logic [255:0] SHA_IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [511:0] PW    = {64'h70617373776f7264, 448'h0};
    localparam logic [31:0]  SALT  = 32'h73616c74;
    localparam logic [255:0] V1    = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
    localparam logic [255:0] V2    = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
    localparam logic [255:0] V4096 = 256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a;
    localparam logic [2:0]   ST_IDLE  = 3'd0;
    localparam logic [2:0]   ST_OWAIT = 3'd4;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        rst_i;
    logic [2:0]  state_o;
    logic [31:0] progress_o;

    pbkdf2_hmac_iter_if #(.SALT_W(SALT_W)) bus ();

    pbkdf2_hmac_iter #(.SALT_W(SALT_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .bus        (bus),
`ifdef PBKDF2_PROGRESS_EN
        .progress_o (progress_o),
`endif
        .state_o    (state_o)
    );

`ifndef PBKDF2_PROGRESS_EN
    assign progress_o = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_hin = 0;
    bit bp_en = 1'b0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    function automatic logic [255:0] sha256_msg(input bq_t m_in);
        bq_t m;
        logic [63:0]  bits;
        logic [511:0] blk;
        logic [255:0] h;
        m = m_in;
        bits = 64'(m.size()) * 64'd8;
        m.push_back(8'h80);
        while (m.size() % 64 != 56) m.push_back(8'h00);
        for (int i = 7; i >= 0; i--) m.push_back(bits[8*i +: 8]);
        h = SHA_IV;
        for (int c0 = 0; c0 < m.size(); c0 += 64) begin
            for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = m[c0+i];
            h = sha_compress(h, blk);
        end
        return h;
    endfunction

    function automatic logic [255:0] hmac_ref(input bq_t key, input bq_t msg);
        bq_t ib, ob;
        logic [7:0]   kb;
        logic [255:0] ih;
        for (int i = 0; i < 64; i++) begin
            kb = (i < key.size()) ? key[i] : 8'h00;
            ib.push_back(kb ^ 8'h36);
            ob.push_back(kb ^ 8'h5c);
        end
        foreach (msg[i]) ib.push_back(msg[i]);
        ih = sha256_msg(ib);
        for (int i = 0; i < 32; i++) ob.push_back(ih[255-8*i -: 8]);
        return sha256_msg(ob);
    endfunction

    function automatic logic [255:0] pbkdf2_ref(input bq_t p, input bq_t s, input logic [31:0] idx, input int c);
        bq_t m;
        logic [255:0] u, t;
        m = s;
        for (int i = 3; i >= 0; i--) m.push_back(idx[8*i +: 8]);
        u = hmac_ref(p, m);
        t = u;
        for (int j = 2; j <= c; j++) begin
            m.delete();
            for (int i = 0; i < 32; i++) m.push_back(u[255-8*i -: 8]);
            u = hmac_ref(p, m);
            t ^= u;
        end
        return t;
    endfunction

    // ---------------- SHA-256 wrapper emulation ----------------
    logic [1023:0] msg_seen;
    logic [255:0]  pend_dig;
    bit            in_vld_seen, out_rdy_seen, pend;
    int            pend_dly, hold_in;

    initial begin : hash_model
        bus.hash_in_ready_i  = 1'b0;
        bus.hash_out_valid_i = 1'b0;
        bus.hash_out_i       = '0;
        in_vld_seen = 1'b0; out_rdy_seen = 1'b0; pend = 1'b0; pend_dly = 0; hold_in = 0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                bus.hash_in_ready_i  = 1'b0;
                bus.hash_out_valid_i = 1'b0;
                pend = 1'b0; in_vld_seen = 1'b0; out_rdy_seen = 1'b0; hold_in = 0;
            end else begin
                if (in_vld_seen && bus.hash_in_ready_i) begin
                    n_hin++;
                    pend_dig = sha_compress(sha_compress(SHA_IV, msg_seen[1023:512]), msg_seen[511:0]);
                    pend     = 1'b1;
                    pend_dly = bp_en ? int'($urandom_range(1, 4)) : 1;
                end else if (in_vld_seen) begin
                    n_vec++;
                    if (bus.hash_in_valid_o !== 1'b1 || bus.hash_in_o !== msg_seen) begin
                        n_err++;
                        $display("FAIL hash_in_stable: valid=%b msg[511:448]=%h required valid=1 msg[511:448]=%h",
                                 bus.hash_in_valid_o, bus.hash_in_o[511:448], msg_seen[511:448]);
                    end
                end
                if (bus.hash_out_valid_i && out_rdy_seen) bus.hash_out_valid_i = 1'b0;
                if (pend && !bus.hash_out_valid_i) begin
                    pend_dly--;
                    if (pend_dly <= 0) begin
                        bus.hash_out_i       = pend_dig;
                        bus.hash_out_valid_i = 1'b1;
                        pend = 1'b0;
                    end
                end
                if (hold_in > 0) begin
                    bus.hash_in_ready_i = 1'b0;
                    hold_in--;
                end else begin
                    bus.hash_in_ready_i = 1'b1;
                    if (bp_en && $urandom_range(0, 2) == 0) hold_in = $urandom_range(1, 20);
                end
            end
            in_vld_seen  = bus.hash_in_valid_o;
            msg_seen     = bus.hash_in_o;
            out_rdy_seen = bus.hash_out_ready_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic submit(input logic [511:0] p, input logic [31:0] s, input logic [31:0] idx,
                          input logic [31:0] c);
        int cyc = 0;
        @(negedge clk);
        bus.pass_i = p; bus.salt_i = s; bus.blk_idx_i = idx; bus.iter_i = c;
        bus.req_valid_i = 1'b1;
        while (!bus.req_ready_o && cyc < 100) begin @(negedge clk); cyc++; end
        n_vec++;
        if (bus.req_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL req_accept: req_ready=%b required 1 within 100 cycles", bus.req_ready_o);
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.pass_i = {16{$urandom}}; bus.salt_i = $urandom; bus.blk_idx_i = $urandom; bus.iter_i = $urandom;
    endtask

    task automatic run_job(input logic [511:0] p, input logic [31:0] s, input logic [31:0] idx,
                           input logic [31:0] c, output logic [255:0] dk, output int nh,
                           output logic [31:0] prog);
        int cyc = 0;
        int start;
        int budget;
        int hold;
        start  = n_hin;
        budget = 100 + ((c == 0) ? 1 : int'(c)) * (bp_en ? 200 : 12);
        submit(p, s, idx, c);
        while (!bus.dk_valid_o && cyc < budget) begin @(negedge clk); cyc++; end
        n_vec++;
        if (bus.dk_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL dk_timeout: dk_valid=%b required 1 within %0d cycles", bus.dk_valid_o, budget);
        end
        dk   = bus.dk_o;
        prog = progress_o;
        hold = bp_en ? int'($urandom_range(1, 20)) : 0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            n_vec++;
            if (bus.dk_valid_o !== 1'b1 || bus.dk_o !== dk) begin
                n_err++;
                $display("FAIL dk_hold: dk_valid=%b dk=%h required 1 %h", bus.dk_valid_o, bus.dk_o, dk);
            end
        end
        bus.dk_ready_i = 1'b1;
        @(negedge clk);
        bus.dk_ready_i = 1'b0;
        nh = n_hin - start;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.req_ready_o, bus.dk_valid_o, bus.hash_in_valid_o, bus.hash_out_ready_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: rdy/dkv/hiv/hor=%b required 0000",
                     {bus.req_ready_o, bus.dk_valid_o, bus.hash_in_valid_o, bus.hash_out_ready_o});
        end
        n_vec++;
        if (bus.dk_o !== '0 || bus.hash_in_o !== '0) begin
            n_err++;
            $display("FAIL reset_data: dk=%h hash_in[63:0]=%h required 0", bus.dk_o, bus.hash_in_o[63:0]);
        end
        n_vec++;
        if (state_o !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: state=%0d required %0d", state_o, ST_IDLE);
        end
        rst_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.req_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL idle_ready: req_ready=%b required 1", bus.req_ready_o);
        end
    endtask

    task automatic test_known(input logic [31:0] c, input logic [255:0] exp, input int exp_nh, input string name);
        logic [255:0] dk;
        logic [31:0]  prog;
        int           nh;
        run_job(PW, SALT, 32'd1, c, dk, nh, prog);
        n_vec++;
        if (dk !== exp) begin
            n_err++;
            $display("FAIL %s_dk: got %h required %h", name, dk, exp);
        end
        n_vec++;
        if (nh != exp_nh) begin
            n_err++;
            $display("FAIL %s_hash_in_count: got %0d required %0d", name, nh, exp_nh);
        end
        n_vec++;
        if (bus.req_ready_o !== 1'b1 || bus.dk_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s_back_to_idle: req_ready=%b dk_valid=%b required 1 0", name, bus.req_ready_o, bus.dk_valid_o);
        end
`ifdef PBKDF2_PROGRESS_EN
        n_vec++;
        if (prog !== 32'(exp_nh / 2)) begin
            n_err++;
            $display("FAIL %s_progress: got %0d required %0d", name, prog, exp_nh / 2);
        end
`endif
    endtask

    task automatic test_vectors();
        test_known(32'd1, V1, 2, "c1");
        test_known(32'd2, V2, 4, "c2");
    endtask

    task automatic test_iter_zero();
        test_known(32'd0, V1, 2, "c0");
    endtask

    task automatic test_backpressure();
        bp_en = 1'b1;
        test_known(32'd2, V2, 4, "bp_c2");
        test_known(32'd1, V1, 2, "bp_c1");
        bp_en = 1'b0;
    endtask

    task automatic test_random();
        bp_en = 1'b1;
        for (int t = 0; t < 4; t++) begin
            bq_t          pq, sq;
            logic [511:0] pv;
            logic [31:0]  sv, iv, cv, prog;
            logic [255:0] exp, dk;
            int           plen, ceff, nh;
            pv   = '0;
            plen = $urandom_range(0, 64);
            for (int i = 0; i < plen; i++) begin
                pv[511-8*i -: 8] = 8'($urandom_range(1, 255));
                pq.push_back(pv[511-8*i -: 8]);
            end
            sv = $urandom;
            for (int i = 0; i < 4; i++) sq.push_back(sv[31-8*i -: 8]);
            iv   = $urandom;
            cv   = $urandom_range(0, 4);
            ceff = (cv == 0) ? 1 : int'(cv);
            exp  = pbkdf2_ref(pq, sq, iv, ceff);
            run_job(pv, sv, iv, cv, dk, nh, prog);
            n_vec++;
            if (dk !== exp) begin
                n_err++;
                $display("FAIL random_dk[%0d]: got %h required %h", t, dk, exp);
            end
            n_vec++;
            if (nh != 2 * ceff) begin
                n_err++;
                $display("FAIL random_hash_in_count[%0d]: got %0d required %0d", t, nh, 2 * ceff);
            end
`ifdef PBKDF2_PROGRESS_EN
            n_vec++;
            if (prog !== 32'(ceff)) begin
                n_err++;
                $display("FAIL random_progress[%0d]: got %0d required %0d", t, prog, ceff);
            end
`endif
        end
        bp_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int         visits = 0;
        int         cyc = 0;
        logic [2:0] prev;
        submit(PW, SALT, 32'd1, 32'd5);
        prev = state_o;
        while (visits < 3 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (state_o == ST_OWAIT && prev != ST_OWAIT) visits++;
            prev = state_o;
        end
        n_vec++;
        if (visits != 3) begin
            n_err++;
            $display("FAIL reset_mid_reach: owait visits=%0d required 3", visits);
        end
        rst_i = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus.req_ready_o, bus.dk_valid_o, bus.hash_in_valid_o, bus.hash_out_ready_o} !== 4'b0000
            || bus.dk_o !== '0 || bus.hash_in_o !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: rdy/dkv/hiv/hor=%b dk=%h required 0000 and zero data",
                     {bus.req_ready_o, bus.dk_valid_o, bus.hash_in_valid_o, bus.hash_out_ready_o}, bus.dk_o);
        end
        n_vec++;
        if (state_o !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_mid_state: state=%0d required %0d", state_o, ST_IDLE);
        end
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        test_known(32'd1, V1, 2, "after_reset");
    endtask

    task automatic test_long();
        test_known(32'd4096, V4096, 8192, "c4096");
    endtask

    initial begin
        rst_i = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.dk_ready_i  = 1'b0;
        bus.pass_i      = '0;
        bus.salt_i      = '0;
        bus.blk_idx_i   = '0;
        bus.iter_i      = '0;
        test_reset();
        test_vectors();
        test_iter_zero();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_long();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
